// File: rtl/robo_step_scheduler.sv
// robo_step_scheduler: paces robot steps from frames or a button, latches sensors, forwards commands to the map
module robo_step_scheduler #(
    parameter int FRAMES_PER_STEP = 30,
    parameter int ACK_TIMEOUT     = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        v_sync,
    input  logic        manual_clock,
    input  logic        mode_auto,
    input  logic        pause,
    input  logic [1:0]  speed,
    input  logic        head,
    input  logic        left,
    input  logic        under,
    input  logic        barrier,
    input  logic        robo_avancar,
    input  logic        robo_girar,
    input  logic        robo_remover,
    input  logic        cmd_ack,
    output logic        robo_step,
    output logic        head_q,
    output logic        left_q,
    output logic        under_q,
    output logic        barrier_q,
    output logic        cmd_valid,
    output logic [1:0]  cmd,
    output logic        busy,
    output logic [15:0] step_count,
    output logic        err_multi,
    output logic        err_timeout,
    output logic        err_overrun
);
    localparam int TW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(ACK_TIMEOUT);
    localparam logic [5:0] LIM0 = 6'(FRAMES_PER_STEP);
    localparam logic [5:0] LIM1 = (FRAMES_PER_STEP / 2 < 1) ? 6'd1 : 6'(FRAMES_PER_STEP / 2);
    localparam logic [5:0] LIM2 = (FRAMES_PER_STEP / 4 < 1) ? 6'd1 : 6'(FRAMES_PER_STEP / 4);

    typedef enum logic [2:0] {IDLE, SAMPLE, STEP, CAPTURE, ISSUE, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    vs_sync_q, vs_sync_d;
    logic [2:0]    mc_sync_q, mc_sync_d;
    logic          vs_edge_q, vs_edge_d;
    logic          mc_edge_q, mc_edge_d;
    logic [5:0]    frame_cnt_q, frame_cnt_d;
    logic [5:0]    limit;
    logic          trigger;
    logic          pend_q, pend_d;
    logic          pend_clr;
    logic [1:0]    cmd_q, cmd_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          head_d, left_d, under_d, barrier_d;
    logic [15:0]   step_count_q, step_count_d;
    logic          err_multi_q, err_multi_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_overrun_q, err_overrun_d;

    assign robo_step   = (state_q == STEP);
    assign cmd_valid   = (state_q == ISSUE);
    assign cmd         = (state_q == ISSUE) ? cmd_q : 2'b00;
    assign busy        = (state_q != IDLE);
    assign step_count  = step_count_q;
    assign err_multi   = err_multi_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;

    // two-stage synchronizers plus previous-value stage; rising edges become registered one-cycle pulses
    always_comb begin
        vs_sync_d = {vs_sync_q[1:0], v_sync};
        mc_sync_d = {mc_sync_q[1:0], manual_clock};
        vs_edge_d = vs_sync_q[1] & ~vs_sync_q[2];
        mc_edge_d = mc_sync_q[1] & ~mc_sync_q[2];
    end

    // frame counter and step trigger; a counter above a freshly lowered limit fires on the next edge
    always_comb begin
        limit       = (speed == 2'b00) ? LIM0 : (speed == 2'b01) ? LIM1 : (speed == 2'b10) ? LIM2 : 6'd1;
        frame_cnt_d = frame_cnt_q;
        trigger     = mc_edge_q & ~mode_auto;
        if (!mode_auto) begin
            frame_cnt_d = '0;
        end else if (!pause && vs_edge_q) begin
            if (frame_cnt_q >= limit - 6'd1) begin
                frame_cnt_d = '0;
                trigger     = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 6'd1;
            end
        end
    end

    // step sequencer: one-deep trigger queue, sensor latch, step enable, command capture and handshake
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        tmo_d         = tmo_q;
        head_d        = head_q;
        left_d        = left_q;
        under_d       = under_q;
        barrier_d     = barrier_q;
        step_count_d  = step_count_q;
        err_multi_d   = err_multi_q;
        err_timeout_d = err_timeout_q;
        pend_clr      = (state_q == IDLE) && pend_q;
        pend_d        = trigger | (pend_q & ~pend_clr);
        err_overrun_d = err_overrun_q | (trigger & pend_q & ~pend_clr);
        case (state_q)
            IDLE: begin
                if (pend_q) state_d = SAMPLE;
            end
            SAMPLE: begin
                head_d    = head;
                left_d    = left;
                under_d   = under;
                barrier_d = barrier;
                state_d   = STEP;
            end
            STEP: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                err_multi_d = err_multi_q | (robo_avancar & robo_girar) | (robo_avancar & robo_remover)
                            | (robo_girar & robo_remover);
                if (robo_avancar | robo_girar | robo_remover) begin
                    cmd_d   = robo_remover ? 2'b11 : robo_girar ? 2'b10 : 2'b01;
                    tmo_d   = '0;
                    state_d = ISSUE;
                end else begin
                    state_d = DONE;
                end
            end
            ISSUE: begin
                if (cmd_ack) begin
                    state_d = DONE;
                end else if (tmo_q == TMO_MAX) begin
                    err_timeout_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE: begin
                step_count_d = step_count_q + 16'd1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state register; everything returns to zero/IDLE immediately on reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            vs_sync_q     <= '0;
            mc_sync_q     <= '0;
            vs_edge_q     <= 1'b0;
            mc_edge_q     <= 1'b0;
            frame_cnt_q   <= '0;
            pend_q        <= 1'b0;
            cmd_q         <= 2'b00;
            tmo_q         <= '0;
            head_q        <= 1'b0;
            left_q        <= 1'b0;
            under_q       <= 1'b0;
            barrier_q     <= 1'b0;
            step_count_q  <= '0;
            err_multi_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_sync_q     <= vs_sync_d;
            mc_sync_q     <= mc_sync_d;
            vs_edge_q     <= vs_edge_d;
            mc_edge_q     <= mc_edge_d;
            frame_cnt_q   <= frame_cnt_d;
            pend_q        <= pend_d;
            cmd_q         <= cmd_d;
            tmo_q         <= tmo_d;
            head_q        <= head_d;
            left_q        <= left_d;
            under_q       <= under_d;
            barrier_q     <= barrier_d;
            step_count_q  <= step_count_d;
            err_multi_q   <= err_multi_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end
endmodule

// File: tb/tb_robo_step_scheduler.sv
// tb_robo_step_scheduler: directed and randomized checks of step pacing, sensor latching and command handshake
module tb_robo_step_scheduler;
    localparam int ACK_TO = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        v_sync = 1'b0;
    logic        manual_clock = 1'b0;
    logic        mode_auto = 1'b0;
    logic        pause = 1'b0;
    logic [1:0]  speed = 2'b00;
    logic        head = 1'b0, left = 1'b0, under = 1'b0, barrier = 1'b0;
    logic        robo_avancar = 1'b0, robo_girar = 1'b0, robo_remover = 1'b0;
    logic        cmd_ack = 1'b0;
    logic        robo_step, hq, lq, uq, bq, cmd_valid, busy;
    logic [1:0]  cmd;
    logic [15:0] step_count;
    logic        err_multi, err_timeout, err_overrun;

    logic [2:0]  robot_plan = 3'b000;
    int          cyc = 0;
    int          pulses = 0;
    int          valid_cycles = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          exp_count = 0;
    logic        exp_multi = 1'b0;
    logic        exp_timeout = 1'b0;

    robo_step_scheduler #(.FRAMES_PER_STEP(30), .ACK_TIMEOUT(ACK_TO)) dut (
        .clock(clk), .reset(reset), .v_sync(v_sync), .manual_clock(manual_clock),
        .mode_auto(mode_auto), .pause(pause), .speed(speed),
        .head(head), .left(left), .under(under), .barrier(barrier),
        .robo_avancar(robo_avancar), .robo_girar(robo_girar), .robo_remover(robo_remover),
        .cmd_ack(cmd_ack), .robo_step(robo_step),
        .head_q(hq), .left_q(lq), .under_q(uq), .barrier_q(bq),
        .cmd_valid(cmd_valid), .cmd(cmd), .busy(busy), .step_count(step_count),
        .err_multi(err_multi), .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // robot stand-in: its registered command outputs take the planned value on each enabled step
    always @(posedge clk) if (robo_step === 1'b1) {robo_remover, robo_girar, robo_avancar} <= robot_plan;

    always @(negedge clk) begin
        if (robo_step === 1'b1) pulses++;
        if (cmd_valid === 1'b1) valid_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [1:0] prio(input logic [2:0] p);
        return p[2] ? 2'b11 : p[1] ? 2'b10 : p[0] ? 2'b01 : 2'b00;
    endfunction

    function automatic int lim(input logic [1:0] s);
        return (s == 2'd0) ? 30 : (s == 2'd1) ? 15 : (s == 2'd2) ? 7 : 1;
    endfunction

    task automatic vsync_edge(input int gap);
        v_sync = 1'b1;
        repeat (3) tick();
        v_sync = 1'b0;
        repeat (gap) tick();
    endtask

    // one full manual step: sens = {head,left,under,barrier}, plan = {remover,girar,avancar}
    task automatic manual_step(input logic [3:0] sens, input logic [2:0] plan, input int ack_dly, input bit no_ack);
        int k, n;
        logic [1:0] ec;
        {head, left, under, barrier} = sens;
        robot_plan = plan;
        manual_clock = 1'b1;
        k = cyc + 1;
        n = 0;
        do begin tick(); n++; end while (busy !== 1'b1 && n < 12);
        manual_clock = 1'b0;
        check("sample_cycle", cyc - k, 4);
        check("step_low_before", robo_step, 0);
        tick();
        check("step_high", robo_step, 1);
        check("sensors", {hq, lq, uq, bq}, sens);
        {head, left, under, barrier} = ~sens;
        tick();
        check("step_low_after", robo_step, 0);
        check("sensors_held", {hq, lq, uq, bq}, sens);
        tick();
        ec = prio(plan);
        if ($countones(plan) > 1) exp_multi = 1'b1;
        if (ec == 2'b00) begin
            check("nocmd_valid", cmd_valid, 0);
            check("nocmd_busy", busy, 1);
        end else begin
            check("cmd_valid", cmd_valid, 1);
            check("cmd", cmd, ec);
            if (no_ack) begin
                n = 1;
                do begin tick(); if (cmd_valid === 1'b1) n++; end while (cmd_valid === 1'b1 && n < 64);
                check("timeout_len", n, ACK_TO + 1);
                exp_timeout = 1'b1;
            end else begin
                for (int i = 0; i < ack_dly; i++) begin
                    tick();
                    check("cmd_hold", {cmd_valid, cmd}, {1'b1, ec});
                end
                cmd_ack = 1'b1;
                tick();
                cmd_ack = 1'b0;
            end
            check("done_cmd", {cmd_valid, cmd}, 3'b000);
        end
        tick();
        exp_count++;
        check("idle", busy, 0);
        check("step_count", step_count, 16'(exp_count));
        check("err_multi", err_multi, exp_multi);
        check("err_timeout", err_timeout, exp_timeout);
    endtask

    initial begin
        int p0, v0, n, cnt, ep;
        repeat (3) tick();
        check("rst_outputs", {robo_step, hq, lq, uq, bq, cmd_valid, cmd, busy, err_multi, err_timeout, err_overrun}, 0);
        check("rst_count", step_count, 0);
        reset = 1'b1;
        repeat (3) tick();
        check("rst_idle", busy, 0);

        manual_step(4'b1000, 3'b010, 3, 1'b0);
        manual_step(4'b0101, 3'b101, 0, 1'b0);
        manual_step(4'b0010, 3'b001, 2, 1'b0);
        manual_step(4'b1111, 3'b000, 0, 1'b0);
        for (int i = 0; i < 10; i++)
            manual_step(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), $urandom_range(0, 10), $urandom_range(0, 7) == 0);
        manual_step(4'b0011, 3'b100, 0, 1'b1);

        mode_auto = 1'b1;
        speed = 2'b11;
        robot_plan = 3'b000;
        p0 = pulses;
        v0 = valid_cycles;
        repeat (3) vsync_edge(997);
        exp_count += 3;
        check("auto11_pulses", pulses - p0, 3);
        check("auto11_count", step_count, 16'(exp_count));
        check("auto11_no_valid", valid_cycles - v0, 0);
        pause = 1'b1;
        p0 = pulses;
        repeat (3) vsync_edge(20);
        check("pause_pulses", pulses - p0, 0);
        pause = 1'b0;
        p0 = pulses;
        manual_clock = 1'b1;
        repeat (4) tick();
        manual_clock = 1'b0;
        repeat (10) tick();
        check("manual_in_auto", pulses - p0, 0);

        speed = 2'b00;
        p0 = pulses;
        for (int i = 1; i <= 60; i++) begin
            vsync_edge(9);
            check("fps_pulses", pulses - p0, i / 30);
        end
        exp_count += 2;
        check("fps_count", step_count, 16'(exp_count));

        cnt = 0;
        ep = 0;
        p0 = pulses;
        for (int i = 0; i < 40; i++) begin
            speed = 2'($urandom_range(0, 3));
            pause = ($urandom_range(0, 3) == 0);
            vsync_edge(9);
            if (!pause) begin
                cnt++;
                if (cnt >= lim(speed)) begin
                    ep++;
                    cnt = 0;
                end
            end
            check("rand_auto_pulses", pulses - p0, ep);
        end
        exp_count += ep;
        pause = 1'b0;
        check("rand_auto_count", step_count, 16'(exp_count));
        mode_auto = 1'b0;
        repeat (4) tick();

        p0 = pulses;
        robot_plan = 3'b001;
        manual_clock = 1'b1;
        repeat (2) tick();
        manual_clock = 1'b0;
        n = 0;
        do begin tick(); n++; end while (cmd_valid !== 1'b1 && n < 20);
        check("ovr_issue", cmd_valid, 1);
        check("ovr_flag_before", err_overrun, 0);
        robot_plan = 3'b000;
        repeat (2) begin
            manual_clock = 1'b1;
            repeat (3) tick();
            manual_clock = 1'b0;
            repeat (3) tick();
        end
        check("ovr_still_issue", cmd_valid, 1);
        check("ovr_flag", err_overrun, 1);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        check("ovr_done", cmd_valid, 0);
        repeat (10) tick();
        exp_count += 2;
        check("ovr_pulses", pulses - p0, 2);
        check("ovr_count", step_count, 16'(exp_count));
        check("ovr_idle", busy, 0);
        check("ovr_sticky", err_overrun, 1);

        robot_plan = 3'b010;
        {head, left, under, barrier} = 4'b1111;
        manual_clock = 1'b1;
        repeat (2) tick();
        manual_clock = 1'b0;
        n = 0;
        do begin tick(); n++; end while (cmd_valid !== 1'b1 && n < 20);
        check("rst_pre_valid", cmd_valid, 1);
        check("rst_pre_head", hq, 1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_outputs", {robo_step, hq, lq, uq, bq, cmd_valid, cmd, busy, err_multi, err_timeout, err_overrun}, 0);
        check("rst_mid_count", step_count, 0);
        tick();
        check("rst_mid_held", {robo_step, cmd_valid, busy}, 0);
        reset = 1'b1;
        repeat (10) tick();
        check("rst_after_idle", {robo_step, cmd_valid, busy}, 0);
        check("rst_after_count", step_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
